// File: rtl/Common.sv
// Shared types for the MLP training datapath.
// Holds activation, tolerance and sequencer state enums.
package Common;

  typedef enum logic [1:0] {
    ACT_SIGMOID,
    ACT_RELU,
    ACT_TANH,
    ACT_LINEAR
  } act_func;

  localparam real epsilon = 1.0e-6;

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    TEST,
    DONE
  } seq_state_t;

endpackage

// File: rtl/sample_store.sv
// Real-valued dataset register file.
// One write port, one combinational read port, cleared on reset.
module sample_store #(
  parameter int inputs  = 2,
  parameter int outputs = 1,
  parameter int samples = 4,
  parameter int AW      = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  real           wvalues_i   [inputs],
  input  real           wexpected_i [outputs],
  input  logic [AW-1:0] raddr_i,
  output real           rvalues_o   [inputs],
  output real           rexpected_o [outputs]
);

  real val_q [samples][inputs];
  real exp_q [samples][outputs];

  logic wr_ok;

  // Writes aimed past the last entry are dropped.
  always_comb begin
    wr_ok = we_i && (int'(waddr_i) < samples);
  end

  // Storage: clear on reset, write one entry per strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < samples; s++) begin
        for (int i = 0; i < inputs; i++)
          val_q[s][i] <= 0.0;
        for (int o = 0; o < outputs; o++)
          exp_q[s][o] <= 0.0;
      end
    end else if (wr_ok) begin
      val_q[waddr_i] <= wvalues_i;
      exp_q[waddr_i] <= wexpected_i;
    end
  end

  // Read port: the sequencer registers whatever this presents.
  always_comb begin
    rvalues_o   = val_q[raddr_i];
    rexpected_o = exp_q[raddr_i];
  end

endmodule

// File: rtl/dataset_sequencer.sv
// Presents a stored dataset to an MLP for N training epochs
// followed by one test pass; all outputs are registered.
module dataset_sequencer
  import Common::*;
#(
  parameter int  inputs      = 2,
  parameter int  outputs     = 1,
  parameter int  samples     = 4,
  parameter int  epochs      = 100,
  parameter int  hold_cycles = 2,
  parameter real lr_init     = 0.1,
  parameter real lr_decay    = 1.0,
  localparam int AW = (samples > 1) ? $clog2(samples) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  real           load_values   [inputs],
  input  real           load_expected [outputs],
  output real           values        [inputs],
  output real           expected      [outputs],
  output logic          training,
  output real           learning_rate,
  output logic          sample_valid,
  output logic          sample_first,
  output logic [AW-1:0] sample_idx,
  output logic [15:0]   epoch,
  output logic          busy,
  output logic          done
);

  localparam int HW =
    (hold_cycles > 1) ? $clog2(hold_cycles) : 1;

  seq_state_t    state_q;
  logic [HW-1:0] hold_q;

  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic          last_hold;
  logic          last_idx;
  logic          last_epoch;
  real           rd_values   [inputs];
  real           rd_expected [outputs];

  // Dataset writes only land while the sequencer is idle.
  always_comb begin
    wr_en = load_en && (state_q == IDLE);
  end

  // Read address is the sample that will be shown next edge.
  always_comb begin
    last_hold  = hold_q == HW'(hold_cycles - 1);
    last_idx   = sample_idx == AW'(samples - 1);
    last_epoch = (epoch + 16'd1) == 16'(epochs);
    rd_addr    = '0;
    if (state_q != IDLE && !last_idx)
      rd_addr = sample_idx + 1'b1;
  end

  sample_store #(
    .inputs  (inputs),
    .outputs (outputs),
    .samples (samples),
    .AW      (AW)
  ) u_store (
    .clk         (clk),
    .rst         (rst),
    .we_i        (wr_en),
    .waddr_i     (load_addr),
    .wvalues_i   (load_values),
    .wexpected_i (load_expected),
    .raddr_i     (rd_addr),
    .rvalues_o   (rd_values),
    .rexpected_o (rd_expected)
  );

  // Sequencer FSM with counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      sample_idx    <= '0;
      epoch         <= '0;
      training      <= 1'b0;
      learning_rate <= lr_init;
      sample_valid  <= 1'b0;
      sample_first  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < inputs; i++)
        values[i] <= 0.0;
      for (int o = 0; o < outputs; o++)
        expected[o] <= 0.0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_q       <= TRAIN;
            hold_q        <= '0;
            sample_idx    <= '0;
            epoch         <= '0;
            training      <= 1'b1;
            learning_rate <= lr_init;
            sample_valid  <= 1'b1;
            sample_first  <= 1'b1;
            busy          <= 1'b1;
            values        <= rd_values;
            expected      <= rd_expected;
          end
        end
        TRAIN, TEST: begin
          if (abort) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            training     <= 1'b0;
            sample_valid <= 1'b0;
            sample_first <= 1'b0;
            busy         <= 1'b0;
          end else if (!last_hold) begin
            hold_q       <= hold_q + 1'b1;
            sample_first <= 1'b0;
          end else if (!last_idx) begin
            hold_q       <= '0;
            sample_idx   <= sample_idx + 1'b1;
            sample_first <= 1'b1;
            values       <= rd_values;
            expected     <= rd_expected;
          end else if (state_q == TRAIN) begin
            hold_q       <= '0;
            sample_idx   <= '0;
            sample_first <= 1'b1;
            epoch        <= epoch + 16'd1;
            values       <= rd_values;
            expected     <= rd_expected;
            if (last_epoch) begin
              state_q  <= TEST;
              training <= 1'b0;
            end else begin
              learning_rate <= learning_rate * lr_decay;
            end
          end else begin
            state_q      <= DONE;
            hold_q       <= '0;
            sample_valid <= 1'b0;
            sample_first <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dataset_sequencer.sv
// Directed and randomized checks of dataset_sequencer
// against a cycle-count reference model.
module tb_dataset_sequencer;

  localparam int  S0 = 4;
  localparam int  H0 = 2;
  localparam int  E0 = 2;
  localparam int  P0 = S0 * H0;
  localparam int  N0 = E0 * P0 + P0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // u0: XOR-style dataset, 4 samples, 2 epochs
  logic       start0, abort0, load_en0;
  logic [1:0] load_addr0;
  real        lv0 [2];
  real        le0 [1];
  real        vo0 [2];
  real        eo0 [1];
  logic       tr0, sv0, sf0, busy0, done0;
  logic [1:0] idx0;
  logic [15:0] ep0;
  real        lr0;

  dataset_sequencer #(
    .inputs(2), .outputs(1), .samples(S0),
    .epochs(E0), .hold_cycles(H0),
    .lr_init(0.1), .lr_decay(0.5)
  ) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .abort(abort0), .load_en(load_en0),
    .load_addr(load_addr0),
    .load_values(lv0), .load_expected(le0),
    .values(vo0), .expected(eo0),
    .training(tr0), .learning_rate(lr0),
    .sample_valid(sv0), .sample_first(sf0),
    .sample_idx(idx0), .epoch(ep0),
    .busy(busy0), .done(done0)
  );

  // u1: minimal 1x1x1 run; u2: 2 samples, 3 epochs
  logic       start1;
  logic       zero1 = 1'b0;
  logic [0:0] za1 = 1'b0;
  real        lv1 [1];
  real        le1 [1];
  real        vo1 [1], eo1 [1], vo2 [1], eo2 [1];
  logic       tr1, sv1, sf1, busy1, done1;
  logic       tr2, sv2, sf2, busy2, done2;
  logic [0:0] idx1, idx2;
  logic [15:0] ep1, ep2;
  real        lr1, lr2;

  dataset_sequencer #(
    .inputs(1), .outputs(1), .samples(1),
    .epochs(1), .hold_cycles(1),
    .lr_init(0.1), .lr_decay(0.5)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1),
    .abort(zero1), .load_en(zero1),
    .load_addr(za1),
    .load_values(lv1), .load_expected(le1),
    .values(vo1), .expected(eo1),
    .training(tr1), .learning_rate(lr1),
    .sample_valid(sv1), .sample_first(sf1),
    .sample_idx(idx1), .epoch(ep1),
    .busy(busy1), .done(done1)
  );

  dataset_sequencer #(
    .inputs(1), .outputs(1), .samples(2),
    .epochs(3), .hold_cycles(1),
    .lr_init(0.1), .lr_decay(0.5)
  ) u2 (
    .clk(clk), .rst(rst), .start(start1),
    .abort(zero1), .load_en(zero1),
    .load_addr(za1),
    .load_values(lv1), .load_expected(le1),
    .values(vo2), .expected(eo2),
    .training(tr2), .learning_rate(lr2),
    .sample_valid(sv2), .sample_first(sf2),
    .sample_idx(idx2), .epoch(ep2),
    .busy(busy2), .done(done2)
  );

  // reference dataset for u0
  real ds_v [S0][2];
  real ds_e [S0];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chkr(string tag, real obs, real exp);
    nvec++;
    assert (obs == exp) else begin
      nerr++;
      $error("FAIL %s: got %f expected %f",
             tag, obs, exp);
    end
  endtask

  task automatic chk_vals(string tag, int e);
    chkr({tag, ".v0"}, vo0[0], ds_v[e][0]);
    chkr({tag, ".v1"}, vo0[1], ds_v[e][1]);
    chkr({tag, ".exp"}, eo0[0], ds_e[e]);
  endtask

  // Expected u0 outputs t cycles after the start edge.
  task automatic chk_u0(int t);
    int  ep, k, id;
    real lr;
    if (t <= N0) begin
      ep = (t - 1) / P0;
      if (ep > E0) ep = E0;
      k  = (t - 1) % P0;
      id = k / H0;
      lr = 0.1;
      for (int i = 0; i < ep && i < E0 - 1; i++)
        lr = lr * 0.5;
      chk("busy", 32'(busy0), 1);
      chk("valid", 32'(sv0), 1);
      chk("done", 32'(done0), 0);
      chk("train", 32'(tr0), 32'(t <= E0 * P0));
      chk("first", 32'(sf0), 32'(k % H0 == 0));
      chk("idx", 32'(idx0), 32'(id));
      chk("epoch", 32'(ep0), 32'(ep));
      chkr("lr", lr0, lr);
      chk_vals("data", id);
    end else begin
      chk("done.pulse", 32'(done0), 1);
      chk("done.busy", 32'(busy0), 0);
      chk("done.valid", 32'(sv0), 0);
      chk("done.epoch", 32'(ep0), E0);
      chk_vals("done.hold", S0 - 1);
    end
  endtask

  task automatic load_u0(int a, real a0, real a1,
                         real e);
    load_en0   = 1'b1;
    load_addr0 = 2'(a);
    lv0        = '{a0, a1};
    le0        = '{e};
    step();
    load_en0   = 1'b0;
    ds_v[a][0] = a0;
    ds_v[a][1] = a1;
    ds_e[a]    = e;
  endtask

  task automatic load_rand();
    for (int a = 0; a < S0; a++)
      load_u0(a,
        real'($urandom_range(0, 255)) / 8.0,
        real'($urandom_range(0, 255)) / 8.0,
        real'($urandom_range(0, 255)) / 8.0);
  endtask

  // Full run; optionally hammer entry 1 while busy.
  task automatic run_u0(bit wr_busy);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int t = 1; t <= N0 + 1; t++) begin
      chk_u0(t);
      if (wr_busy && t < N0) begin
        load_en0   = 1'b1;
        load_addr0 = 2'd1;
        lv0        = '{9.0, 9.0};
        le0        = '{9.0};
      end else begin
        load_en0 = 1'b0;
      end
      step();
    end
    chk("idle.done", 32'(done0), 0);
    chk("idle.busy", 32'(busy0), 0);
    chk_vals("idle.hold", S0 - 1);
  endtask

  initial begin
    rst = 1'b1;
    start0 = 0; abort0 = 0; load_en0 = 0;
    load_addr0 = 0; start1 = 0;
    lv0 = '{0.0, 0.0}; le0 = '{0.0};
    lv1 = '{0.0}; le1 = '{0.0};
    for (int a = 0; a < S0; a++) begin
      ds_v[a][0] = 0.0;
      ds_v[a][1] = 0.0;
      ds_e[a]    = 0.0;
    end
    #3;
    chk("rst.busy", 32'(busy0), 0);
    chk("rst.valid", 32'(sv0), 0);
    chk("rst.idx", 32'(idx0), 0);
    chkr("rst.lr", lr0, 0.1);
    chk_vals("rst.data", 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // XOR table, plain run
    load_u0(0, 0.0, 0.0, 0.0);
    load_u0(1, 0.0, 1.0, 1.0);
    load_u0(2, 1.0, 0.0, 1.0);
    load_u0(3, 1.0, 1.0, 0.0);
    run_u0(1'b0);

    // abort on the 5th TRAIN cycle
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      chk_u0(t);
      if (t == 5) abort0 = 1'b1;
      step();
    end
    abort0 = 1'b0;
    for (int t = 0; t < 3; t++) begin
      chk("abort.busy", 32'(busy0), 0);
      chk("abort.valid", 32'(sv0), 0);
      chk("abort.train", 32'(tr0), 0);
      chk("abort.epoch", 32'(ep0), 0);
      chk("abort.done", 32'(done0), 0);
      step();
    end

    // random dataset, writes during the run ignored
    load_rand();
    run_u0(1'b1);

    // asynchronous reset in the middle of TEST
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int t = 1; t <= E0 * P0 + 3; t++) begin
      chk_u0(t);
      step();
    end
    rst = 1'b1;
    #2;
    chk("arst.busy", 32'(busy0), 0);
    chk("arst.valid", 32'(sv0), 0);
    chk("arst.first", 32'(sf0), 0);
    chk("arst.epoch", 32'(ep0), 0);
    chk("arst.idx", 32'(idx0), 0);
    chkr("arst.lr", lr0, 0.1);
    for (int a = 0; a < S0; a++) begin
      ds_v[a][0] = 0.0;
      ds_v[a][1] = 0.0;
      ds_e[a]    = 0.0;
    end
    chk_vals("arst.data", 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    load_rand();
    run_u0(1'b0);

    // u1 (1x1x1) and u2 (lr decay over 3 epochs)
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      real lr;
      if (t <= 2) begin
        chk("u1.busy", 32'(busy1), 1);
        chk("u1.valid", 32'(sv1), 1);
        chk("u1.first", 32'(sf1), 1);
        chk("u1.train", 32'(tr1), 32'(t == 1));
        chk("u1.done", 32'(done1), 0);
      end else if (t == 3) begin
        chk("u1.pulse", 32'(done1), 1);
        chk("u1.busy", 32'(busy1), 0);
      end else begin
        chk("u1.done", 32'(done1), 0);
      end
      lr = (t <= 2) ? 0.1 : (t <= 4) ? 0.05 : 0.025;
      if (t <= 8) begin
        chkr("u2.lr", lr2, lr);
        chk("u2.train", 32'(tr2), 32'(t <= 6));
        chk("u2.idx", 32'(idx2), 32'((t - 1) % 2));
        chk("u2.epoch", 32'(ep2),
            32'((t <= 6) ? (t - 1) / 2 : 3));
      end else begin
        chk("u2.pulse", 32'(done2), 1);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dataset_sequencer.md
DATASET_SEQUENCER -- requirements
Module: dataset_sequencer

Interface
REQ-001 The module SHALL have parameter inputs, default 2: feature count per sample.
REQ-002 The module SHALL have parameter outputs, default 1: label count per sample.
REQ-003 The module SHALL have parameter samples, default 4: dataset depth, at least 1.
REQ-004 The module SHALL have parameter epochs, default 100: training passes, at least 1, at most 65535.
REQ-005 The module SHALL have parameter hold_cycles, default 2: cycles each sample is presented, at least 1.
REQ-006 The module SHALL have parameter lr_init, type real, default 0.1: first-epoch learning rate.
REQ-007 The module SHALL have parameter lr_decay, type real, default 1.0: per-epoch learning-rate multiplier.
REQ-008 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-009 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-010 The module SHALL have port start, input, 1 bit: begin a run.
REQ-011 The module SHALL have port abort, input, 1 bit: cancel a run.
REQ-012 The module SHALL have port load_en, input, 1 bit: dataset write strobe.
REQ-013 The module SHALL have port load_addr, input, $clog2(samples) bits (minimum 1): write index.
REQ-014 The module SHALL have port load_values, input, real[inputs]: features to store.
REQ-015 The module SHALL have port load_expected, input, real[outputs]: labels to store.
REQ-016 The module SHALL have port values, output, real[inputs]: features to the MLP.
REQ-017 The module SHALL have port expected, output, real[outputs]: labels to the MLP.
REQ-018 The module SHALL have port training, output, 1 bit: MLP weight-update enable.
REQ-019 The module SHALL have port learning_rate, output, real: current learning rate.
REQ-020 The module SHALL have port sample_valid, output, 1 bit: values and expected are meaningful.
REQ-021 The module SHALL have port sample_first, output, 1 bit: first hold cycle of a sample.
REQ-022 The module SHALL have port sample_idx, output, $clog2(samples) bits: current sample.
REQ-023 The module SHALL have port epoch, output, 16 bits: completed training epochs.
REQ-024 The module SHALL have port busy, output, 1 bit: a run is in progress.
REQ-025 The module SHALL have port done, output, 1 bit: one-cycle pulse at run end.

Function
REQ-026 The module SHALL implement FSM states IDLE, TRAIN, TEST and DONE; all outputs SHALL be registered.
REQ-027 In IDLE, load_en SHALL write load_values and load_expected to entry load_addr at the clock edge; load_en outside IDLE SHALL be ignored, and load_addr at or above samples SHALL be ignored.
REQ-028 A start sampled in IDLE SHALL move the FSM to TRAIN on that edge, with sample_idx=0, epoch=0, learning_rate=lr_init, training=1, sample_valid=1, sample_first=1 and values/expected equal to entry 0; start outside IDLE SHALL be ignored.
REQ-029 In TRAIN and TEST, each sample SHALL be held for exactly hold_cycles consecutive cycles, with sample_first high only on the first of them.
REQ-030 After the last hold cycle of a sample, the next sample (sample_idx+1) SHALL be presented on the next cycle, with no gap cycles.
REQ-031 When sample samples-1 completes in TRAIN, epoch SHALL increment, learning_rate SHALL become learning_rate*lr_decay, and sample_idx SHALL wrap to 0.
REQ-032 When epoch reaches epochs, the FSM SHALL enter TEST with training=0 and learning_rate held at its last value, then present one pass over all samples.
REQ-033 When the TEST pass completes, the FSM SHALL enter DONE for one cycle (done=1, sample_valid=0, busy=0) and then return to IDLE.
REQ-034 busy SHALL be 1 exactly in TRAIN and TEST.
REQ-035 abort in TRAIN or TEST SHALL enter IDLE on the next edge with sample_valid=0, training=0, no done pulse, and epoch held; abort SHALL take priority over all sample advancement.
REQ-036 A run SHALL last epochs*samples*hold_cycles TRAIN cycles plus samples*hold_cycles TEST cycles plus 1 DONE cycle.
REQ-037 In IDLE and DONE, values and expected SHALL hold their last driven contents.

Reset
REQ-038 While rst is high, the FSM SHALL be IDLE, every dataset entry and all real outputs SHALL be 0.0 except learning_rate=lr_init, and all bit and vector outputs SHALL be 0.
REQ-039 Reset asserted mid-run SHALL abandon the run immediately, asynchronously, and without a done pulse.

Structure
REQ-040 The enum seq_state_t {IDLE, TRAIN, TEST, DONE} SHALL be added to package Common alongside act_func and epsilon.
REQ-041 The dataset storage SHALL be a sub-module named sample_store (a real-valued register file: one write port, one read port, cleared on reset); the FSM and counters SHALL remain in dataset_sequencer.

Verification
REQ-042 Load the XOR table, epochs=2, hold_cycles=2, start -> TRAIN for 16 cycles with index order 0,0,1,1,2,2,3,3 repeated, then TEST for 8 cycles with training=0, then done pulse exactly 25 cycles after start.
REQ-043 lr_init=0.1, lr_decay=0.5, epochs=3 -> learning_rate is 0.1, then 0.05, then 0.025 during training, and stays 0.025 in TEST.
REQ-044 Abort at the 5th TRAIN cycle -> IDLE on the next cycle, busy=0, epoch=0, no done pulse; a following start replays from sample 0.
REQ-045 load_en during TRAIN writing entry 1 with [9,9] -> entry 1 still presents its original values in later epochs.
REQ-046 rst pulsed mid-TEST -> outputs go to their reset values without waiting for a clock edge; a reload of the dataset plus start runs a normal sequence.
REQ-047 samples=1, hold_cycles=1, epochs=1 -> one TRAIN cycle, one TEST cycle, then done; sample_first=1 in both the TRAIN and TEST cycles.
